// File: rtl/pmem_arbiter.sv
// pmem_arbiter: round-robin share of one registered memory port between instruction fetch and data access
module pmem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_read,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_resp,
    input  logic                    d_read,
    input  logic                    d_write,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_byte_enable,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_resp,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_resp,
    output logic                    mem_timeout
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    state_t state, state_n;
    logic last_d, d_req, grant_i, grant_d;
    logic [CW-1:0] count;
    always_comb begin
        d_req   = d_read | d_write;
        // on a tie the port that did not win last time goes first
        grant_i = (state == IDLE) && i_read && (!d_req || last_d);
        grant_d = (state == IDLE) && d_req && !grant_i;
        state_n = grant_i ? BUSY_I :
                  grant_d ? BUSY_D :
                  (state != IDLE && mem_resp) ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            last_d          <= 1'b1;
            count           <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
            mem_timeout     <= 1'b0;
        end else begin
            state <= state_n;
            if (grant_i) begin
                last_d          <= 1'b0;
                count           <= '0;
                mem_read        <= 1'b1;
                mem_write       <= 1'b0;
                mem_addr        <= i_addr;
                mem_byte_enable <= '1;
            end else if (grant_d) begin
                last_d          <= 1'b1;
                count           <= '0;
                mem_read        <= !d_write;
                mem_write       <= d_write;
                mem_addr        <= d_addr;
                mem_wdata       <= d_wdata;
                mem_byte_enable <= d_write ? d_byte_enable : '1;
            end else if (state != IDLE) begin
                if (mem_resp) begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end else if (count != CW'(TIMEOUT_CYCLES)) begin
                    count <= count + CW'(1);
                    if (count == CW'(TIMEOUT_CYCLES - 1)) mem_timeout <= 1'b1;
                end
            end
        end
    end
    assign i_resp  = (state == BUSY_I) && mem_resp;
    assign d_resp  = (state == BUSY_D) && mem_resp;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed checks of arbitration, strobe timing, timeout and reset recovery
module tb_pmem_arbiter;
    localparam int TO = 16;
    logic        clk = 0, rst = 1;
    logic        i_read = 0, d_read = 0, d_write = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
    logic [3:0]  d_byte_enable = 0;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        i_resp, d_resp, mem_read, mem_write, mem_resp, mem_timeout;
    logic [3:0]  mem_byte_enable;
    int n_tests = 0, n_fail = 0;
    int delay = 1, withhold = 0, cnt = 0;
    int both_hi = 0, gap_err = 0, dual_resp = 0, n_dresp = 0;
    bit prev_resp = 0;
    int who;

    pmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    // memory answers `delay` cycles after the strobe appears; read data is a fixed function of the address
    initial begin
        mem_resp = 0;
        mem_rdata = 0;
        forever begin
            @(negedge clk);
            mem_resp = 0;
            if (rst || !(mem_read || mem_write)) cnt = 0;
            else if (withhold == 0) begin
                cnt++;
                if (cnt >= delay) begin
                    mem_resp = 1;
                    mem_rdata = mem_addr ^ 32'hA5A5_0000;
                    cnt = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mem_read && mem_write) both_hi++;
            if (i_resp && d_resp) dual_resp++;
            if (prev_resp && (mem_read || mem_write)) gap_err++;
            if (d_resp) n_dresp++;
            prev_resp = i_resp || d_resp;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // returns 1 for an instruction response, 2 for data, 0 if nothing arrived within the budget
    task automatic wait_any(output int w);
        w = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            #2;
            if (i_resp || d_resp) begin
                w = i_resp ? 1 : 2;
                break;
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        #2;
        chk("rst_read", mem_read, 0);
        chk("rst_write", mem_write, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_be", mem_byte_enable, 0);
        chk("rst_resp", {i_resp, d_resp}, 0);
        chk("rst_timeout", mem_timeout, 0);

        delay = 2;
        i_read = 1;
        i_addr = 32'h60;
        @(negedge clk);
        #1;
        chk("t1_read", mem_read, 1);
        chk("t1_addr", mem_addr, 32'h60);
        chk("t1_be", mem_byte_enable, 4'hF);
        wait_any(who);
        i_read = 0;
        chk("t1_who", who, 1);
        chk("t1_rdata", i_rdata, 32'h60 ^ 32'hA5A5_0000);

        delay = 3;
        d_write = 1;
        d_addr = 32'h104;
        d_wdata = 32'hDEAD_BEEF;
        d_byte_enable = 4'b0011;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("t2_write", mem_write, 1);
        chk("t2_read", mem_read, 0);
        chk("t2_addr", mem_addr, 32'h104);
        wait_any(who);
        d_write = 0;
        chk("t2_who", who, 2);
        chk("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t2_be", mem_byte_enable, 4'b0011);

        rst = 1;
        @(negedge clk);
        rst = 0;
        delay = 1;
        i_read = 1;
        i_addr = 32'h200;
        d_read = 1;
        d_addr = 32'h300;
        wait_any(who);
        chk("t3_first", who, 1);
        chk("t3_irdata", i_rdata, 32'h200 ^ 32'hA5A5_0000);
        i_read = 0;
        wait_any(who);
        chk("t3_second", who, 2);
        chk("t3_drdata", d_rdata, 32'h300 ^ 32'hA5A5_0000);
        d_read = 0;
        @(negedge clk);

        i_read = 1;
        d_read = 1;
        for (int n = 0; n < 4; n++) begin
            wait_any(who);
            if (n == 3) begin
                i_read = 0;
                d_read = 0;
            end
            chk($sformatf("t4_order%0d", n), who, (n % 2 == 0) ? 1 : 2);
        end
        @(negedge clk);

        withhold = 1;
        d_read = 1;
        d_addr = 32'h400;
        repeat (TO) @(negedge clk);
        #2;
        chk("t5_not_yet", mem_timeout, 0);
        @(negedge clk);
        #2;
        chk("t5_timeout", mem_timeout, 1);
        withhold = 0;
        wait_any(who);
        d_read = 0;
        chk("t5_resp", who, 2);
        repeat (3) @(negedge clk);
        #2;
        chk("t5_sticky", mem_timeout, 1);

        delay = 5;
        d_write = 1;
        d_addr = 32'h500;
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("t6_write", mem_write, 1);
        n_dresp = 0;
        rst = 1;
        @(negedge clk);
        #2;
        chk("t6_rst_write", mem_write, 0);
        chk("t6_rst_timeout", mem_timeout, 0);
        d_write = 0;
        rst = 0;
        repeat (8) @(negedge clk);
        chk("t6_no_dresp", n_dresp, 0);
        delay = 2;
        i_read = 1;
        i_addr = 32'h640;
        wait_any(who);
        i_read = 0;
        chk("t6_ifetch", who, 1);
        chk("t6_rdata", i_rdata, 32'h640 ^ 32'hA5A5_0000);
        @(negedge clk);

        chk("both_strobes", both_hi, 0);
        chk("strobe_gap", gap_err, 0);
        chk("dual_resp", dual_resp, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
